ahbl_master_arb2: RTL
=====================

# ahbl_master_arb2

Two-master AHB-Lite arbiter between the EL2 core's instruction port (M0) and LSU port (M1) and the single master port of the system bus fabric. It lets both masters issue address phases at any time, captures requests that lose arbitration, and replays them onto the shared bus. Uncontended transfers pass through with zero added latency. Data-phase signals are steered to the master that owns the current data phase.

## Interface

Parameters:
- `AW`, 32, address width
- `DW`, 32, data width

Ports:
- `HCLK` in 1: single clock.
- `HRESETn` in 1: asynchronous, active-low reset.
- `M0_HADDR`/`M1_HADDR` in AW; `Mx_HTRANS` in 2; `Mx_HWRITE` in 1; `Mx_HSIZE` in 3: master address phase.
- `Mx_HWDATA` in DW: master write data.
- `Mx_HREADY` out 1; `Mx_HRESP` out 1; `Mx_HRDATA` out DW: master response.
- `Mx_HGRANT` out 1: `x` is the current address-phase owner.
- `S_HADDR` out AW; `S_HTRANS` out 2; `S_HWRITE` out 1; `S_HSIZE` out 3; `S_HWDATA` out DW: to the fabric.
- `S_HREADY` in 1; `S_HRESP` in 1; `S_HRDATA` in DW: from the fabric.

## Operation

- **Per-master FSM states:** IDLE, HELD, DATA. Each master has one hold register (`HADDR`/`HTRANS`/`HWRITE`/`HSIZE`).
- **`Mx_HREADY`:**
  - 1 in IDLE.
  - 0 in HELD.
  - `S_HREADY` in DATA.
- **`Mx_HRESP`:** `S_HRESP` in DATA, else 0.
- **`Mx_HRDATA`:** `S_HRDATA` broadcast to both masters.
- **Requests:**
  - Live request: `Mx_HTRANS[1]` & `Mx_HREADY`. BUSY/IDLE are not requests.
  - Candidate: `x` is a candidate if it is HELD or has a live request.
- **Arbitration:** evaluated only when `S_HREADY`=1.
  - Winner is chosen among candidates by fixed priority, M1 > M0.
  - Winner is stored in `asel_q`. With no candidate, `asel_q` is unchanged (parking).
- **Slave address mux:**
  - When `S_HREADY`=1, select the winner (or `asel_q` if there is no candidate).
  - When `S_HREADY`=0, select `asel_q`.
  - Source is the hold register if that master is HELD, else its live bus.
- **Transitions** (evaluated when `x` is not HELD and `Mx_HREADY`=1):
  - Live request and `x` wins → DATA.
  - Live request and `x` loses, or `S_HREADY`=0 → capture into hold register, go to HELD.
  - No request → IDLE.
- **HELD → DATA:** when `S_HREADY`=1 and `x` wins.
- **DATA with `S_HREADY`=0:** stays in DATA.
- **Invariants:**
  - At most one master is in DATA.
  - Each master has at most one of {held, live-pending} outstanding.
- **`S_HWDATA`:** `Mx_HWDATA` of the DATA master, else 0.
- **Error response:** two-cycle ERROR passes through to the DATA owner only.
- **Starvation:** a continuously pipelining M1 starves M0 in fixed-priority mode. This is accepted.

## Timing

Reset values (apply immediately on `HRESETn` low):
- Both FSMs IDLE; `asel_q`=0.
- `M0_HGRANT`=1, `M1_HGRANT`=0.
- `Mx_HREADY`=1, `Mx_HRESP`=0.
- `S_HTRANS` forced to 00 while `HRESETn`=0.

Timing rules:
- **Uncontended:** 0 added cycles. `S_HADDR` equals `Mx_HADDR` in the same cycle.
- **Loser:** its request is issued at the next cycle with `S_HREADY`=1 in which it wins (minimum +1 cycle). Its `HREADY` is low from the cycle after capture until its replayed data phase completes.
- **Request during a slave wait state:** always captured (HELD). Slave-side outputs stay stable while `S_HREADY`=0.
- **Simultaneous requests:** M1 goes live and M0 is captured in the same cycle.
- **Reset mid-operation:** held transfers are discarded and never replayed.

## Configuration

- **`ARB_RR_EN` defined:** round-robin arbitration. When both masters are candidates, the master that did not win last gets priority. The last-winner flag resets to M1, so M0 wins the first tie.
- **`ARB_RR_EN` undefined:** fixed priority, M1 > M0.

## Test plan

- **Single master, zero wait:** M0 NONSEQ read 0x0000_0100 → `S_HADDR`=0x100 in the same cycle, `M0_HGRANT`=1, `M0_HREADY` never 0.
- **Simultaneous requests:** M0 read 0x100 and M1 write 0x2000_0000 in cycle 0 → M1 issued cycle 0; M0 HELD with `M0_HREADY`=0 in cycle 1; `S_HADDR`=0x100 in cycle 1; M0 data completes cycle 2.
- **Request during wait states:** M1 data phase with 2 wait states while M0 issues 0x40 → M0 captured; `S_HADDR`/`S_HTRANS` stable during the waits; 0x40 issued on the first `S_HREADY`=1 cycle.
- **Starvation vs round-robin:** both masters issue back-to-back NONSEQ for 8 cycles → fixed mode gives M0 0 grants; `ARB_RR_EN` gives 4 grants each, alternating.
- **Error response:** `S_HRESP`=1 for 2 cycles on an M1 data phase → `M1_HRESP`=1 both cycles, `M1_HREADY` goes 0 then 1, `M0_HRESP`=0 throughout.
- **Reset while HELD:** pull `HRESETn` low while M0 is HELD → `M0_HREADY`=1 and `S_HTRANS`=00 immediately; no replay after reset is released.

Source files
------------

// File: rtl/ahbl_master_arb2.sv
// Two-master AHB-Lite arbiter: instruction port (M0) and LSU port (M1) share one
// fabric master port. Losing or wait-stalled requests are captured in a per-master
// hold register and replayed; uncontended transfers pass straight through.
// Optional feature: define ARB_RR_EN for round-robin arbitration (default is
// fixed priority, M1 over M0).
module ahbl_master_arb2 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [DW-1:0] M0_HWDATA,
    output logic          M0_HREADY,
    output logic          M0_HRESP,
    output logic [DW-1:0] M0_HRDATA,
    output logic          M0_HGRANT,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [DW-1:0] M1_HWDATA,
    output logic          M1_HREADY,
    output logic          M1_HRESP,
    output logic [DW-1:0] M1_HRDATA,
    output logic          M1_HGRANT,
    output logic [AW-1:0] S_HADDR,
    output logic [1:0]    S_HTRANS,
    output logic          S_HWRITE,
    output logic [2:0]    S_HSIZE,
    output logic [DW-1:0] S_HWDATA,
    input  logic          S_HREADY,
    input  logic          S_HRESP,
    input  logic [DW-1:0] S_HRDATA
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e        state_q     [2];
    state_e        state_d     [2];
    logic [AW-1:0] holdAddr_q  [2];
    logic [AW-1:0] holdAddr_d  [2];
    logic [1:0]    holdTrans_q [2];
    logic [1:0]    holdTrans_d [2];
    logic          holdWrite_q [2];
    logic          holdWrite_d [2];
    logic [2:0]    holdSize_q  [2];
    logic [2:0]    holdSize_d  [2];
    logic          asel_q;
    logic          asel_d;
`ifdef ARB_RR_EN
    logic          lastWin_q;
    logic          lastWin_d;
`endif

    logic [AW-1:0] mAddr  [2];
    logic [1:0]    mTrans [2];
    logic          mWrite [2];
    logic [2:0]    mSize  [2];

    logic [1:0] mReady;
    logic [1:0] live;
    logic [1:0] held;
    logic [1:0] cand;
    logic [1:0] winIs;
    logic       winner;
    logic       sel;
    logic [1:0] slvTrans;

    assign mAddr[0]  = M0_HADDR;
    assign mAddr[1]  = M1_HADDR;
    assign mTrans[0] = M0_HTRANS;
    assign mTrans[1] = M1_HTRANS;
    assign mWrite[0] = M0_HWRITE;
    assign mWrite[1] = M1_HWRITE;
    assign mSize[0]  = M0_HSIZE;
    assign mSize[1]  = M1_HSIZE;

    // Per-master ready as seen by the master, and which masters want the bus now
    always_comb begin
        mReady = 2'b11;
        held   = 2'b00;
        live   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            case (state_q[i])
                ST_HELD: begin
                    mReady[i] = 1'b0;
                    held[i]   = 1'b1;
                end
                ST_DATA: mReady[i] = S_HREADY;
                default: mReady[i] = 1'b1;
            endcase
            live[i] = mTrans[i][1] & mReady[i];
        end
    end

    assign cand = live | held;

    // Pick the winner among candidates; with no candidate the address owner stays parked
    always_comb begin
`ifdef ARB_RR_EN
        winner    = (cand[0] & cand[1]) ? ~lastWin_q : cand[1];
        lastWin_d = (S_HREADY & (|cand)) ? winner : lastWin_q;
`else
        winner    = cand[1];
`endif
        winIs  = {winner, ~winner};
        sel    = (S_HREADY & (|cand)) ? winner : asel_q;
        asel_d = sel;
    end

    // Per-master transitions: issue on a win, otherwise capture into the hold register
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i]     = state_q[i];
            holdAddr_d[i]  = holdAddr_q[i];
            holdTrans_d[i] = holdTrans_q[i];
            holdWrite_d[i] = holdWrite_q[i];
            holdSize_d[i]  = holdSize_q[i];
            case (state_q[i])
                ST_HELD: begin
                    if (S_HREADY & winIs[i]) begin
                        state_d[i] = ST_DATA;
                    end
                end
                default: begin
                    if (mReady[i]) begin
                        if (!live[i]) begin
                            state_d[i] = ST_IDLE;
                        end else if (S_HREADY & winIs[i]) begin
                            state_d[i] = ST_DATA;
                        end else begin
                            state_d[i]     = ST_HELD;
                            holdAddr_d[i]  = mAddr[i];
                            holdTrans_d[i] = mTrans[i];
                            holdWrite_d[i] = mWrite[i];
                            holdSize_d[i]  = mSize[i];
                        end
                    end
                end
            endcase
        end
    end

    // State, hold registers and arbitration memory; reset drops any held transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i]     <= ST_IDLE;
                holdAddr_q[i]  <= '0;
                holdTrans_q[i] <= 2'b00;
                holdWrite_q[i] <= 1'b0;
                holdSize_q[i]  <= 3'b000;
            end
            asel_q <= 1'b0;
`ifdef ARB_RR_EN
            lastWin_q <= 1'b1;
`endif
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i]     <= state_d[i];
                holdAddr_q[i]  <= holdAddr_d[i];
                holdTrans_q[i] <= holdTrans_d[i];
                holdWrite_q[i] <= holdWrite_d[i];
                holdSize_q[i]  <= holdSize_d[i];
            end
            asel_q <= asel_d;
`ifdef ARB_RR_EN
            lastWin_q <= lastWin_d;
`endif
        end
    end

    // Slave address phase comes from the selected master's hold register or live bus
    always_comb begin
        if (held[sel]) begin
            S_HADDR  = holdAddr_q[sel];
            slvTrans = holdTrans_q[sel];
            S_HWRITE = holdWrite_q[sel];
            S_HSIZE  = holdSize_q[sel];
        end else begin
            S_HADDR  = mAddr[sel];
            slvTrans = mTrans[sel];
            S_HWRITE = mWrite[sel];
            S_HSIZE  = mSize[sel];
        end
    end

    assign S_HTRANS = HRESETn ? slvTrans : 2'b00;

    // Write data follows whichever master owns the data phase
    always_comb begin
        S_HWDATA = '0;
        if (state_q[1] == ST_DATA) begin
            S_HWDATA = M1_HWDATA;
        end else if (state_q[0] == ST_DATA) begin
            S_HWDATA = M0_HWDATA;
        end
    end

    assign M0_HREADY = mReady[0];
    assign M1_HREADY = mReady[1];
    assign M0_HRESP  = (state_q[0] == ST_DATA) & S_HRESP;
    assign M1_HRESP  = (state_q[1] == ST_DATA) & S_HRESP;
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;
    assign M0_HGRANT = ~HRESETn | ~sel;
    assign M1_HGRANT = HRESETn & sel;

endmodule
